// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU and loader) for one shared memory port.
// Each access is granted in IDLE, issued for one cycle, waited out for LAT cycles and acknowledged.
module mem_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   // A requester holds req (with we/addr/wdata stable) until its one-cycle ready
   // pulse; a req still high in the ready cycle is treated as a fresh access.
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ready,
   output logic [DW-1:0] cpu_rdata,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          ld_ready,
   output logic [DW-1:0] ld_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [1:0]    grant,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          lock_q, lock_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          we_q, we_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] ld_rdata_q, ld_rdata_d;

   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          rd_resp;

   assign sel_we    = gnt_q[1] ? ld_we    : cpu_we;
   assign sel_addr  = gnt_q[1] ? ld_addr  : cpu_addr;
   assign sel_wdata = gnt_q[1] ? ld_wdata : cpu_wdata;
   assign rd_resp   = (state_q == RESP) && !we_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= 1'b1;
         lock_q      <= 1'b0;
         gnt_q       <= 2'b00;
         we_q        <= 1'b0;
         cpu_rdata_q <= '0;
         ld_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         lock_q      <= lock_d;
         gnt_q       <= gnt_d;
         we_q        <= we_d;
         cpu_rdata_q <= cpu_rdata_d;
         ld_rdata_q  <= ld_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      lock_d      = lock_q;
      gnt_d       = gnt_q;
      we_d        = we_q;
      cpu_rdata_d = cpu_rdata_q;
      ld_rdata_d  = ld_rdata_q;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      cpu_ready   = 1'b0;
      ld_ready    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_req || ld_req) begin
               // On a conflict the loader wins when the CPU went last, or when it holds the lock.
               if (cpu_req && ld_req)
                  gnt_d = (!last_q || lock_q) ? 2'b10 : 2'b01;
               else
                  gnt_d = ld_req ? 2'b10 : 2'b01;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
            cnt_d     = CNT_INIT;
            we_d      = sel_we;
            state_d   = (sel_we || LAT == 1) ? RESP : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1)
               state_d = RESP;
         end
         RESP: begin
            cpu_ready = gnt_q[0];
            ld_ready  = gnt_q[1];
            if (rd_resp) begin
               if (gnt_q[0]) cpu_rdata_d = mem_rdata;
               if (gnt_q[1]) ld_rdata_d  = mem_rdata;
            end
            last_d  = gnt_q[1];
            lock_d  = gnt_q[1] & ld_lock;
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   assign cpu_rdata = (rd_resp && gnt_q[0]) ? mem_rdata : cpu_rdata_q;
   assign ld_rdata  = (rd_resp && gnt_q[1]) ? mem_rdata : ld_rdata_q;
   assign grant     = gnt_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT 1, 3, 4), each with a small read-latency memory model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 3;

   typedef struct {
      int          k;
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          drop_at;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   logic          cpu_req [N], cpu_we [N], ld_req [N], ld_we [N], ld_lock [N];
   logic          cpu_ready [N], ld_ready [N], mem_en [N], mem_we [N], busy [N];
   logic [AW-1:0] cpu_addr [N], ld_addr [N], mem_addr [N];
   logic [DW-1:0] cpu_wdata [N], ld_wdata [N], cpu_rdata [N], ld_rdata [N];
   logic [DW-1:0] mem_wdata [N], mem_rdata [N];
   logic [1:0]    grant [N], dbg_state [N];

   logic [34:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;
   int we_stray = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
   endfunction

   for (genvar g = 0; g < N; g++) begin : gen_dut
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
      int          age = 0;
      logic [31:0] ra  = '0;

      mem_arbiter #(.AW(AW), .DW(DW), .LAT(L)) u_dut (
         .clk(clk), .reset(reset),
         .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
         .cpu_wdata(cpu_wdata[g]), .cpu_ready(cpu_ready[g]), .cpu_rdata(cpu_rdata[g]),
         .ld_req(ld_req[g]), .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_wdata(ld_wdata[g]),
         .ld_lock(ld_lock[g]), .ld_ready(ld_ready[g]), .ld_rdata(ld_rdata[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
         .grant(grant[g]), .busy(busy[g]), .dbg_state(dbg_state[g])
      );

      // Read data is valid only in the cycle exactly L cycles after the issue cycle.
      always @(posedge clk) begin
         if (mem_en[g] && !mem_we[g]) begin
            age <= 1;
            ra  <= mem_addr[g];
         end else if (age != 0 && age < 100) begin
            age <= age + 1;
         end
      end
      assign mem_rdata[g] = (age == L) ? rd_val(ra) : (32'hBAD0_0000 | 32'(g));
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic pop_cmp(input int k, input bit port, input logic [31:0] rdata);
      logic [34:0] act, e;
      act = {2'(k), port, rdata};
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_ready: got %0h, expected no ready", act);
      end else begin
         e = exp_q.pop_front();
         if (act === e) n_pass++;
         else $display("FAIL ready_scoreboard: got %0h, expected %0h", act, e);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            if (mem_we[k] && !mem_en[k]) we_stray++;
            if (cpu_ready[k]) pop_cmp(k, 1'b0, cpu_rdata[k]);
            if (ld_ready[k])  pop_cmp(k, 1'b1, ld_rdata[k]);
         end
      end
   end

   task automatic drop_req(input int k, input bit port);
      if (port) ld_req[k] = 1'b0;
      else      cpu_req[k] = 1'b0;
   endtask

   // Called at a falling edge with the instance idle; that cycle is cycle 0.
   task automatic run_access(input vec_t v);
      int  issue_c, ready_c, en_cnt;
      bit  rdy;
      if (v.port) begin
         ld_req[v.k] = 1'b1; ld_we[v.k] = v.we; ld_addr[v.k] = v.addr; ld_wdata[v.k] = v.wdata;
      end else begin
         cpu_req[v.k] = 1'b1; cpu_we[v.k] = v.we; cpu_addr[v.k] = v.addr; cpu_wdata[v.k] = v.wdata;
      end
      exp_q.push_back({2'(v.k), v.port, v.exp_rdata});
      issue_c = -1; ready_c = -1; en_cnt = 0;
      for (int c = 1; c <= 20 && ready_c < 0; c++) begin
         @(negedge clk);
         if (v.drop_at == c) drop_req(v.k, v.port);
         if (mem_en[v.k]) begin
            en_cnt++;
            if (issue_c < 0) issue_c = c;
            check("mem_addr", 64'(mem_addr[v.k]), 64'(v.addr));
            check("mem_we", 64'(mem_we[v.k]), 64'(v.we));
            if (v.we) check("mem_wdata", 64'(mem_wdata[v.k]), 64'(v.wdata));
         end
         check("grant_owner", 64'(grant[v.k]), v.port ? 64'h2 : 64'h1);
         rdy = v.port ? ld_ready[v.k] : cpu_ready[v.k];
         if (rdy) begin
            ready_c = c;
            drop_req(v.k, v.port);
         end
      end
      check("issue_cycle", 64'(issue_c), 64'(1));
      check("mem_en_cycles", 64'(en_cnt), 64'(1));
      check("ready_cycle", 64'(ready_c), 64'(v.exp_lat));
      @(negedge clk);
      check("busy_after", 64'(busy[v.k]), 64'(0));
      check("grant_after", 64'(grant[v.k]), 64'(0));
      repeat (2) @(negedge clk);
      check("rdata_hold", v.port ? 64'(ld_rdata[v.k]) : 64'(cpu_rdata[v.k]), 64'(v.exp_rdata));
   endtask

   vec_t vecs [10];
   vec_t v;

   initial begin
      int nrdy, last_rdy, nld;
      bit got_cpu;

      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         cpu_req[k] = 0; cpu_we[k] = 0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
         ld_req[k] = 0; ld_we[k] = 0; ld_addr[k] = '0; ld_wdata[k] = '0; ld_lock[k] = 0;
      end

      //           k  port we  addr          wdata         exp_rdata     lat drop
      vecs[0] = '{0, 0, 0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 2, 0};
      vecs[1] = '{0, 0, 1, 32'h0000_0020, 32'h1234_5678, 32'hDEAD_BEEF, 2, 0};
      vecs[2] = '{0, 1, 0, 32'h0000_0044, 32'h0,        32'h0044_FFBB, 2, 0};
      vecs[3] = '{0, 1, 1, 32'h0000_0048, 32'hCAFE_F00D, 32'h0044_FFBB, 2, 0};
      vecs[4] = '{1, 1, 0, 32'h0000_0080, 32'h0,        32'h0080_FF7F, 4, 0};
      vecs[5] = '{1, 0, 0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 4, 0};
      vecs[6] = '{1, 0, 1, 32'h0000_0030, 32'h5555_AAAA, 32'hDEAD_BEEF, 2, 0};
      vecs[7] = '{2, 0, 0, 32'h0000_0100, 32'h0,        32'h0100_FEFF, 5, 0};
      vecs[8] = '{2, 1, 0, 32'h0000_FFFC, 32'h0,        32'hFFFC_0003, 5, 0};
      vecs[9] = '{2, 0, 0, 32'h0000_0700, 32'h0,        32'h0700_F8FF, 5, 2};

      repeat (3) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         check("reset_ctrl", {58'b0, grant[k], busy[k], mem_en[k], mem_we[k], cpu_ready[k] | ld_ready[k]}, 64'(0));
         check("reset_rdata", {cpu_rdata[k], ld_rdata[k]}, 64'(0));
         check("reset_state", 64'(dbg_state[k]), 64'(0));
      end
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_access(vecs[i]);

      // Fairness on LAT=1: loader went last, so CPU first, then strict alternation.
      cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h200;
      ld_req[0] = 1;  ld_we[0] = 0;  ld_addr[0] = 32'h300;
      exp_q.push_back({2'd0, 1'b0, 32'h0200_FDFF});
      exp_q.push_back({2'd0, 1'b1, 32'h0300_FCFF});
      exp_q.push_back({2'd0, 1'b0, 32'h0200_FDFF});
      exp_q.push_back({2'd0, 1'b1, 32'h0300_FCFF});
      nrdy = 0; last_rdy = -1;
      for (int c = 1; c <= 40 && nrdy < 4; c++) begin
         @(negedge clk);
         check("fair_one_ready", 64'(cpu_ready[0] & ld_ready[0]), 64'(0));
         if (cpu_ready[0] || ld_ready[0]) begin
            nrdy++;
            if (last_rdy >= 0) check("ready_spacing", 64'(c - last_rdy), 64'(3));
            else check("fair_first_ready", 64'(c), 64'(2));
            last_rdy = c;
            if (nrdy == 4) begin cpu_req[0] = 0; ld_req[0] = 0; end
         end
      end
      check("fair_ready_count", 64'(nrdy), 64'(4));
      repeat (3) @(negedge clk);

      // Locked loader burst on LAT=3: three loader writes, then the CPU read.
      cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h40;
      ld_req[1] = 1;  ld_we[1] = 1;  ld_addr[1] = 32'h90; ld_wdata[1] = 32'h0BAD_CAFE; ld_lock[1] = 1;
      repeat (3) exp_q.push_back({2'd1, 1'b1, 32'h0080_FF7F});
      exp_q.push_back({2'd1, 1'b0, 32'h0040_FFBF});
      nld = 0; got_cpu = 0;
      for (int c = 1; c <= 60 && !got_cpu; c++) begin
         @(negedge clk);
         if (ld_ready[1]) begin
            nld++;
            check("cpu_rdata_in_burst", 64'(cpu_rdata[1]), 64'(32'hDEAD_BEEF));
            if (nld == 3) ld_lock[1] = 0;
         end
         if (cpu_ready[1]) begin
            got_cpu = 1;
            check("burst_ld_count", 64'(nld), 64'(3));
            cpu_req[1] = 0; ld_req[1] = 0;
         end
      end
      check("burst_cpu_served", 64'(got_cpu), 64'(1));
      repeat (3) @(negedge clk);

      // Reset in WAIT on LAT=4: abandoned access, then a clean access.
      cpu_req[2] = 1; cpu_we[2] = 0; cpu_addr[2] = 32'h500;
      repeat (2) @(negedge clk);
      check("pre_reset_wait", 64'(dbg_state[2]), 64'(2));
      reset = 1'b0;
      #1;
      check("rst_mem_en", 64'(mem_en[2]), 64'(0));
      check("rst_grant", 64'(grant[2]), 64'(0));
      check("rst_busy", 64'(busy[2]), 64'(0));
      check("rst_rdata", 64'(cpu_rdata[2]), 64'(0));
      cpu_req[2] = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      v = '{2, 0, 0, 32'h0000_0600, 32'h0, 32'h0600_F9FF, 5, 0};
      run_access(v);

      check("exp_q_empty", 64'(exp_q.size()), 64'(0));
      check("mem_we_outside_issue", 64'(we_stray), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single shared memory port of the multi-cycle MIPS core. It lets the CPU (instruction fetch and load/store through one port) and the program loader/debug port share one memory. A request is granted, issued to memory, waited out for a fixed read latency, and acknowledged with a one-cycle ready pulse. While its request is pending, the CPU's ready is held low, and the core's controller uses this to stall the state machine.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 1, memory read latency in cycles from the issue cycle to valid mem_rdata; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_ready
- cpu_we  in  1  CPU write enable; stable while cpu_req
- cpu_addr  in  AW  CPU address; stable while cpu_req
- cpu_wdata  in  DW  CPU write data
- cpu_ready  out  1  one-cycle completion pulse to the CPU
- cpu_rdata  out  DW  CPU read data
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request, same rules as the CPU port
- ld_lock  in  1  loader asks to keep priority for its next access (burst)
- ld_ready  out  1  one-cycle completion pulse to the loader
- ld_rdata  out  DW  loader read data
- mem_en  out  1  memory access strobe, high for exactly one cycle per access
- mem_we  out  1  memory write enable; meaningful only while mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid LAT cycles after the issue cycle
- grant  out  2  {ld, cpu} one-hot owner of the current transaction; 00 when idle
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. A 4-bit down-counter `cnt` and a `last` register (0 = CPU, 1 = loader) support it.
- IDLE: if any request is present, latch the grant and go to ISSUE. Otherwise stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester that is not `last`.
  - Exception: if `last` = loader and the lock flag is set, the loader wins.
- ISSUE:
  - Drive mem_en=1. Drive mem_we/mem_addr/mem_wdata from the granted port.
  - Load cnt = LAT-1.
  - A write, or a read with LAT=1, goes to RESP. Otherwise go to WAIT.
- WAIT: decrement cnt each cycle. Go to RESP in the cycle after cnt reaches 1.
- RESP:
  - Pulse the granted port's ready for one cycle.
  - For a read, capture mem_rdata into that port's rdata register.
  - Set `last` = grantee.
  - If the grantee is the loader, set the lock flag from ld_lock; otherwise clear the lock flag.
  - Go to IDLE.
- Read data outputs:
  - In the RESP cycle of a read, the grantee's rdata equals mem_rdata combinationally.
  - Afterwards it holds the captured value until that port's next read completes.
  - Writes never change rdata.
- Outside ISSUE: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
- Dropping req before ready is a protocol violation. The transaction still completes and ready still pulses. req and ready may overlap: a port may drop req in the ready cycle or keep it for a new access.

## Timing
- Reset (asynchronous, active-low), applies immediately even mid-transaction:
  - State goes to IDLE.
  - grant=00, busy=0, mem_en=0, mem_we=0.
  - All ready=0, both rdata=0.
  - last=loader, so the CPU wins the first conflict; lock=0.
  - An in-flight access is abandoned with no ready pulse.
- Latency, counted from the cycle req is first sampled high in IDLE:
  - mem_en is high in cycle +1.
  - ready is high in cycle +2 for writes and cycle +1+LAT for reads.
  - Minimum access length is 3 cycles. The next arbitration happens in the IDLE cycle after RESP, so back-to-back accesses are spaced 3+ cycles.
- A req that arrives while the FSM is not in IDLE waits. It is evaluated only in IDLE.
- Fairness: under continuous requests from both ports, grants alternate CPU, loader, CPU, and so on.
- ld_lock starves the CPU for as long as the loader keeps ld_lock asserted at each of its RESP cycles.

## Test plan
- Reset and single CPU read, LAT=1: cpu_req at cycle 0, addr 0x0000_0010; memory returns 0xDEAD_BEEF.
  - Required: mem_en at cycle 1 with mem_addr 0x10; cpu_ready and cpu_rdata=0xDEAD_BEEF at cycle 2.
  - Required: cpu_rdata still holds 0xDEAD_BEEF at cycle 5.
- LAT=3 loader read: ld_req at cycle 0.
  - Required: mem_en at cycle 1, ld_ready at cycle 4, grant=10 from cycles 1 to 4, busy low at cycle 5.
- Simultaneous requests after reset, both held:
  - Required grant order: CPU, loader, CPU, loader.
  - Required: exactly one ready per access, with ready pulses 3 cycles apart when LAT=1.
- Loader burst with ld_lock=1 for 3 writes while cpu_req stays high:
  - Required: the loader wins 3 times, then the CPU wins once ld_lock drops.
  - Required: mem_we=1 only in the issue cycles; cpu_rdata unchanged.
- Reset asserted during WAIT (LAT=4):
  - Required: mem_en=0, grant=00, and busy=0 immediately.
  - Required: no ready pulse for the abandoned access; the next access after release completes normally.
- Protocol violation: cpu_req dropped in the WAIT state.
  - Required: cpu_ready still pulses at cycle 1+LAT, and the FSM returns to IDLE.
